// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma data-port DMA engine.
package mem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        WR,
        FIN
    } state_e;

    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;
    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    // True when an address's low bits are not a multiple of the element size.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return (sz != SZ_BYTE) &&
               (((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00)));
    endfunction

endpackage

// File: rtl/mem_dma.sv
// Small DMA engine driving the OTTER memory data port; copies LEN byte/half/word
// elements. Optional constant-fill mode is enabled with `define MEM_DMA_FILL_EN.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] SRC_ADDR,
    input  logic [ADDR_W-1:0] DST_ADDR,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [1:0]        SIZE,
`ifdef MEM_DMA_FILL_EN
    input  logic              FILL,
`endif
    input  logic              GRANT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              MEM_RDEN2,
    output logic              MEM_WE2,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [31:0]       MEM_WD,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [31:0]       MEM_DOUT2
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sz_q, sz_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] inc;
    logic              reject;
    logic              fill_req;
    logic              fill_act;

`ifdef MEM_DMA_FILL_EN
    logic fill_q, fill_d;
    assign fill_req = FILL;
    assign fill_act = fill_q;
`else
    assign fill_req = 1'b0;
    assign fill_act = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            sz_q    <= SZ_WORD;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef MEM_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            sz_q    <= sz_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef MEM_DMA_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    // Port strobes follow GRANT in the same cycle so the arbiter never sees a
    // stale request; everything else is decoded from registered state.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        sz_d      = sz_q;
        data_d    = data_q;
        err_d     = err_q;
`ifdef MEM_DMA_FILL_EN
        fill_d    = fill_q;
`endif
        inc       = ADDR_W'(1) << sz_q;
        reject    = 1'b0;
        BUSY      = (state_q != IDLE);
        DONE      = 1'b0;
        ERR       = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        MEM_ADDR2 = '0;
        MEM_WD    = '0;
        MEM_SIZE  = SZ_WORD;
        MEM_SIGN  = 1'b1;

        case (state_q)
            IDLE: begin
                if (START) begin
                    src_d  = SRC_ADDR;
                    dst_d  = DST_ADDR;
                    cnt_d  = LEN;
                    sz_d   = SIZE;
`ifdef MEM_DMA_FILL_EN
                    fill_d = FILL;
`endif
                    data_d = fill_req ? 32'(SRC_ADDR) : data_q;
                    reject = (SIZE > SZ_WORD) ||
                             misaligned(SIZE, DST_ADDR[1:0]) ||
                             (!fill_req && misaligned(SIZE, SRC_ADDR[1:0]));
                    err_d  = reject;
                    if (reject || (LEN == '0)) begin
                        state_d = FIN;
                    end else if (fill_req) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                MEM_ADDR2 = src_q;
                MEM_SIZE  = sz_q;
                MEM_RDEN2 = GRANT;
                if (GRANT) begin
                    state_d = RD_CAP;
                end
            end
            // Address and size held: memory sizes DOUT2 from the live address.
            RD_CAP: begin
                MEM_ADDR2 = src_q;
                MEM_SIZE  = sz_q;
                if (GRANT) begin
                    data_d  = MEM_DOUT2;
                    state_d = WR;
                end else begin
                    state_d = RD_REQ;
                end
            end
            WR: begin
                MEM_ADDR2 = dst_q;
                MEM_SIZE  = sz_q;
                MEM_WD    = data_q;
                MEM_WE2   = GRANT;
                if (GRANT) begin
                    src_d = src_q + inc;
                    dst_d = dst_q + inc;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = FIN;
                    end else if (fill_act) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FIN: begin
                DONE    = 1'b1;
                ERR     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: byte-array memory model, queue-based expected
// transfers/writes, randomized copies checked against a reference copy model.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        grant = 1'b1;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [1:0]  size = '0;
`ifdef MEM_DMA_FILL_EN
    logic        fill = 1'b0;
`endif
    logic        busy, done, err;
    logic        mem_rden2, mem_we2, mem_sign;
    logic [31:0] mem_addr2, mem_wd, mem_dout2;
    logic [1:0]  mem_size;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] rd_word_q = '0;

    typedef struct {
        logic err;
        int   busy;
        int   rd;
        int   wr;
    } txn_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sz;
    } wr_t;

    txn_t exp_txn[$];
    wr_t  exp_wr[$];
    int   compared = 0;
    int   mismatched = 0;
    int   busy_cnt = 0, rd_cnt = 0, wr_cnt = 0;

    mem_dma dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .SRC_ADDR(src_addr),
        .DST_ADDR(dst_addr), .LEN(len), .SIZE(size),
`ifdef MEM_DMA_FILL_EN
        .FILL(fill),
`endif
        .GRANT(grant), .BUSY(busy), .DONE(done), .ERR(err),
        .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2),
        .MEM_WD(mem_wd), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign),
        .MEM_DOUT2(mem_dout2)
    );

    always #5 clk = ~clk;

    // Memory: registered word read, sized (zero-extended) combinationally.
    function automatic logic [31:0] size_read(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz);
        logic [31:0] s;
        s = w >> (32'(off) * 8);
        case (sz)
            2'd0:    return {24'd0, s[7:0]};
            2'd1:    return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_dout2 = size_read(rd_word_q, mem_addr2[1:0], mem_size);

    always @(posedge clk) begin
        logic [9:0] a;
        if (mem_rden2) begin
            a = {mem_addr2[9:2], 2'b00};
            rd_word_q <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        end
        if (mem_we2) begin
            for (int b = 0; b < (1 << mem_size) && b < 4; b++)
                mem[10'(mem_addr2[9:0] + 10'(b))] = mem_wd[8*b +: 8];
        end
    end

    // Monitor: protocol checks every cycle, write and completion scoreboards.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        end else begin
            compared++;
            if ((mem_rden2 && mem_we2) || ((mem_rden2 || mem_we2) && !grant) ||
                (err && !done) || (mem_sign !== 1'b1)) begin
                mismatched++;
                $display("FAIL protocol: rden2=%b we2=%b grant=%b err=%b done=%b sign=%b",
                         mem_rden2, mem_we2, grant, err, done, mem_sign);
            end
            if (busy) busy_cnt++;
            if (mem_rden2) rd_cnt++;
            if (mem_we2) begin
                wr_t w;
                wr_cnt++;
                compared++;
                if (exp_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL write_unexpected: addr=%h data=%h", mem_addr2, mem_wd);
                end else begin
                    w = exp_wr.pop_front();
                    if (mem_addr2 !== w.addr || mem_wd !== w.data || mem_size !== w.sz) begin
                        mismatched++;
                        $display("FAIL write: got addr=%h data=%h size=%0d, want addr=%h data=%h size=%0d",
                                 mem_addr2, mem_wd, mem_size, w.addr, w.data, w.sz);
                    end
                end
            end
            if (done) begin
                txn_t t;
                compared++;
                if (exp_txn.size() == 0) begin
                    mismatched++;
                    $display("FAIL done_unexpected: err=%b busy_cycles=%0d", err, busy_cnt);
                end else begin
                    t = exp_txn.pop_front();
                    if (err !== t.err || busy_cnt != t.busy || rd_cnt != t.rd || wr_cnt != t.wr) begin
                        mismatched++;
                        $display("FAIL xfer: got err=%b busy=%0d rd=%0d wr=%0d, want err=%b busy=%0d rd=%0d wr=%0d",
                                 err, busy_cnt, rd_cnt, wr_cnt, t.err, t.busy, t.rd, t.wr);
                    end
                end
                busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference copy: element-by-element, in order, from the spec's rules.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [1:0] sz, input logic fm, input int limit,
                         output logic e);
        int          nb;
        logic [31:0] elem;
        wr_t         w;
        nb = 1 << sz;
        e  = (sz == 2'd3) || ((d % nb) != 0) || (!fm && ((s % nb) != 0));
        if (!e) begin
            for (int i = 0; i < n && i < limit; i++) begin
                elem = '0;
                for (int b = 0; b < nb; b++) begin
                    if (fm) elem[8*b +: 8] = s[8*b +: 8];
                    else    elem[8*b +: 8] = ref_mem[10'(s + 32'(i * nb + b))];
                end
                for (int b = 0; b < nb; b++)
                    ref_mem[10'(d + 32'(i * nb + b))] = elem[8*b +: 8];
                w.addr = d + 32'(i * nb);
                w.data = fm ? s : elem;
                w.sz   = sz;
                exp_wr.push_back(w);
            end
        end
    endtask

    task automatic check_mem(input int lo, input int hi, input string name);
        int bad = -1;
        compared++;
        for (int i = lo; i <= hi; i++)
            if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL %s: mem[%h]=%h want %h", name, bad, mem[bad], ref_mem[bad]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [71:0] got, want;
        got  = {busy, done, err, mem_rden2, mem_we2, mem_addr2, mem_wd, mem_size, mem_sign};
        want = {5'b0, 32'd0, 32'd0, 2'd2, 1'b1};
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: outputs=%h want %h", name, got, want);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input logic [1:0] sz, input logic fm, input logic [63:0] drop,
                            input int mid, input int extra_busy, input int extra_rd);
        logic e;
        txn_t t;
        bit   finished = 0;
        model(s, d, n, sz, fm, n, e);
        t.err  = e;
        t.busy = (e || n == 0) ? 1 : ((fm ? n + 1 : 3 * n + 1) + extra_busy);
        t.rd   = (e || fm || n == 0) ? 0 : n + extra_rd;
        t.wr   = e ? 0 : n;
        exp_txn.push_back(t);
        src_addr = s; dst_addr = d; len = 16'(n); size = sz;
`ifdef MEM_DMA_FILL_EN
        fill = fm;
`endif
        grant = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (exp_txn.size() == 0) begin
                finished = 1;
                break;
            end
            grant = (cyc < 64) ? !drop[cyc] : 1'b1;
            if (cyc == mid) begin
                start    = 1'b1;
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = 16'($urandom_range(1, 50));
                size     = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        grant = 1'b1;
        if (!finished) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: no DONE for src=%h dst=%h len=%0d", s, d, n);
            exp_txn.delete();
            exp_wr.delete();
            pulse_reset();
        end
    endtask

    initial begin
        logic [31:0] words [4];
        logic        e;
        logic [63:0] drop;
        words[0] = 32'h1122_3344; words[1] = 32'hA5B6_C7D8;
        words[2] = 32'h0F1E_2D3C; words[3] = 32'hCAFE_F00D;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 16; i++) begin
            mem[256 + i]     = words[i / 4][8*(i % 4) +: 8];
            ref_mem[256 + i] = mem[256 + i];
        end

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        run_xfer(32'h100, 32'h200, 4, 2'd2, 1'b0, '0, 0, 0, 0);
        check_mem(32'h200, 32'h20F, "word_copy");

        run_xfer(32'h101, 32'h203, 3, 2'd0, 1'b0, '0, 0, 0, 0);
        check_mem(32'h202, 32'h206, "byte_copy");

        // Drop GRANT for RD_CAP of element 2 plus the following cycle, then for two WR cycles.
        drop = '0;
        drop[5] = 1'b1; drop[6] = 1'b1; drop[9] = 1'b1; drop[10] = 1'b1;
        run_xfer(32'h120, 32'h220, 3, 2'd1, 1'b0, drop, 0, 5, 1);
        check_mem(32'h220, 32'h225, "grant_drop");

        run_xfer(32'h102, 32'h210, 2, 2'd2, 1'b0, '0, 0, 0, 0);
        run_xfer(32'h100, 32'h210, 2, 2'd3, 1'b0, '0, 0, 0, 0);
        run_xfer(32'h100, 32'h211, 1, 2'd1, 1'b0, '0, 0, 0, 0);
        run_xfer(32'h100, 32'h210, 0, 2'd2, 1'b0, '0, 0, 0, 0);
        check_mem(32'h210, 32'h21F, "rejects_untouched");

        run_xfer(32'h130, 32'h230, 4, 2'd2, 1'b0, '0, 5, 0, 0);
        check_mem(32'h230, 32'h23F, "start_while_busy");

        // Reset during WR of element 2: only element 1 reaches memory, no DONE.
        model(32'h140, 32'h240, 4, 2'd2, 1'b0, 1, e);
        src_addr = 32'h140; dst_addr = 32'h240; len = 16'd4; size = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        check_mem(32'h240, 32'h24F, "reset_abort");

`ifdef MEM_DMA_FILL_EN
        run_xfer(32'hDEADBEEF, 32'h300, 2, 2'd2, 1'b1, '0, 0, 0, 0);
        check_mem(32'h300, 32'h307, "fill_word");
        run_xfer(32'h0000_1235, 32'h310, 3, 2'd1, 1'b1, '0, 0, 0, 0);
        check_mem(32'h310, 32'h315, "fill_half");
`endif

        for (int k = 0; k < 24; k++) begin
            logic [31:0] s, d;
            logic [1:0]  sz;
            logic        fm;
            int          n;
            s  = 32'($urandom_range(0, 383));
            d  = 32'($urandom_range(512, 895));
            n  = $urandom_range(0, 8);
            sz = 2'($urandom_range(0, 3));
            fm = 1'b0;
`ifdef MEM_DMA_FILL_EN
            fm = 1'($urandom_range(0, 1));
            if (fm) s = $urandom;
`endif
            run_xfer(s, d, n, sz, fm, '0, 0, 0, 0);
        end

        step();
        compared++;
        if (exp_txn.size() != 0 || exp_wr.size() != 0) begin
            mismatched++;
            $display("FAIL queues_drained: txn=%0d writes=%0d left, want 0/0",
                     exp_txn.size(), exp_wr.size());
        end
        check_mem(0, 1023, "final_memory");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Data-port initiator for the OTTER memory block: a small DMA engine that copies LEN elements (byte, half or word) from SRC_ADDR to DST_ADDR.
- Drives the memory's data-port signals (RDEN2 / WE2 / ADDR2 / WD / SIZE / SIGN) and consumes DOUT2.
- Sits behind an external arbiter that multiplexes the data port between the CPU and this block; the block touches the port only while GRANT=1.

Parameters:
- LEN_W, 16, width of the element counter.
- ADDR_W, 32, width of the source, destination and memory address buses.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request; sampled only in IDLE
- SRC_ADDR  in  ADDR_W  source byte address
- DST_ADDR  in  ADDR_W  destination byte address
- LEN  in  LEN_W  element count
- SIZE  in  2  element size: 0 byte, 1 half, 2 word
- GRANT  in  1  arbiter grants the data port to the DMA
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle pulse, coincident with DONE, on a rejected request
- MEM_RDEN2  out  1  data read enable
- MEM_WE2  out  1  data write enable
- MEM_ADDR2  out  ADDR_W  data address
- MEM_WD  out  32  write data
- MEM_SIZE  out  2  access size
- MEM_SIGN  out  1  always 1 (unsigned), so reads zero-extend into the low bits
- MEM_DOUT2  in  32  sized read data from memory

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State returns to IDLE.
  - BUSY=0, DONE=0, ERR=0, MEM_RDEN2=0, MEM_WE2=0, MEM_ADDR2=0, MEM_WD=0, MEM_SIZE=2, MEM_SIGN=1.
  - Reset mid-transfer aborts immediately and issues no DONE.
- On START in IDLE, latch SRC_ADDR, DST_ADDR, LEN and SIZE into src, dst, cnt and sz.
- Rejects (go to FIN with ERR=1, no memory access):
  - SIZE=3.
  - SIZE=1 with SRC_ADDR[0] or DST_ADDR[0] set.
  - SIZE=2 with SRC_ADDR[1:0] or DST_ADDR[1:0] nonzero.
- LEN=0 goes to FIN with ERR=0 and no access.
- START while BUSY is ignored.
- States:
  - IDLE: waits for START.
  - RD_REQ: MEM_ADDR2=src, MEM_SIZE=sz, MEM_RDEN2=GRANT. Goes to RD_CAP when GRANT=1.
  - RD_CAP: holds MEM_ADDR2=src and MEM_SIZE=sz, because memory sizes the read combinationally from the current address. RDEN2=0.
    - GRANT=1: capture MEM_DOUT2 into the data register, then go to WR.
    - GRANT=0: return to RD_REQ and re-issue the read.
  - WR: MEM_ADDR2=dst, MEM_WD=data, MEM_WE2=GRANT. When GRANT=1:
    - src += 1<<sz, dst += 1<<sz, cnt -= 1.
    - Go to FIN if cnt was 1, else to RD_REQ.
  - FIN: DONE=1 (ERR if flagged) for exactly one cycle, then IDLE.
- BUSY=1 in every state except IDLE.
- Throughput: 3 cycles per element with GRANT held high. A LEN=N transfer has BUSY high for 3N+1 cycles (the FIN cycle included).
- MEM_RDEN2 and MEM_WE2 are never asserted in the same cycle, and never while GRANT=0.
- Address increments wrap modulo 2^ADDR_W; no bounds check.
- Addresses ≥ 0x10000 are legal; memory routes them to MMIO (IO_WR, IO buffer).
- MEM_WD carries the element in its low bits, which matches the memory's sb/sh lane placement.

Optional Feature:
- Macro MEM_DMA_FILL_EN.
- Defined:
  - Adds input port FILL (1 bit), latched on START.
  - FILL=1 skips RD_REQ/RD_CAP: the data register is loaded with SRC_ADDR at START, and every element is written with that value.
  - Costs 1 cycle per element; BUSY high for N+1 cycles.
  - Only DST_ADDR alignment is checked.
- Undefined: no FILL port; copy mode only.

Decomposition:
- Package mem_dma_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_CAP, WR, FIN);
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - MMIO_BASE=32'h10000.
- Single module; no sub-module is warranted.

Test Plan:
1. Word copy: mem[0x100..0x10C]={A,B,C,D}, START, SIZE=2, LEN=4, DST=0x200, GRANT=1 -> BUSY high 13 cycles, one DONE pulse, ERR=0, mem[0x200..0x20C]={A,B,C,D}.
2. Byte copy: SRC=0x101, DST=0x203, LEN=3, SIZE=0 -> bytes 0x203..0x205 equal source bytes 0x101..0x103; neighbouring bytes 0x202 and 0x206 unchanged.
3. GRANT dropped for 2 cycles in RD_CAP, and again in WR -> read re-issued, no RDEN2/WE2 while GRANT=0, final data correct.
4. SIZE=2, SRC=0x102 (and separately SIZE=3) -> DONE+ERR one cycle after START, zero RDEN2/WE2 cycles.
5. LEN=0 -> DONE one cycle after START, ERR=0, no access. START pulsed mid-transfer -> ignored; original transfer completes unchanged.
6. RST_N low during WR of element 2 of 4 -> outputs at reset values asynchronously, no DONE, only element 1 written. With MEM_DMA_FILL_EN: FILL=1, SRC=0xDEADBEEF, LEN=2, SIZE=2 -> two words written, BUSY 3 cycles.
